// File: rtl/screen_probe_ctrl_if.sv
// screen_probe_ctrl_if: capture-path video, config bus and detection status for screen_probe_ctrl
interface screen_probe_ctrl_if;
  logic        Enable;
  logic        VSyncPulse;
  logic        HSyncPulse;
  logic        VDE;
  logic [23:0] RGB;
  logic        CfgWe;
  logic [3:0]  CfgAddr;
  logic [31:0] CfgData;
  logic        Detected;
  logic        DetectedSticky;
  logic [3:0]  FrameMask;
  logic [3:0]  ConsecCount;
  modport master (
    output Enable, VSyncPulse, HSyncPulse, VDE, RGB, CfgWe, CfgAddr, CfgData,
    input  Detected, DetectedSticky, FrameMask, ConsecCount
  );
  modport slave (
    input  Enable, VSyncPulse, HSyncPulse, VDE, RGB, CfgWe, CfgAddr, CfgData,
    output Detected, DetectedSticky, FrameMask, ConsecCount
  );
endinterface

// File: rtl/screen_probe_ctrl.sv
// screen_probe_ctrl: runtime-programmable pixel-probe screen detector with per-frame debounce
module screen_probe_ctrl #(
  parameter int NUM_PROBES = 4,
  parameter int MAX_FRAMES = 15
) (
  input logic CLK,
  input logic RST,
  screen_probe_ctrl_if.slave bus
);
  logic [10:0] px [NUM_PROBES];
  logic [9:0]  py [NUM_PROBES];
  logic [23:0] prgb [NUM_PROBES];
  logic [7:0]  ptol [NUM_PROBES];
  logic [3:0]  en_mask, frames_req, req_eff;
  logic [10:0] x;
  logic [9:0]  y;
  logic        line_act;
  logic [NUM_PROBES-1:0] hit, fmask, eval_mask;
  logic [3:0]  frame_out, cnt;
  logic        det, det_q, stk, cfg_clr, sticky_clr, frame_ok;
  function automatic logic [7:0] absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : b - a;
  endfunction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_PROBES; i++) begin
        px[i] <= '0;
        py[i] <= '0;
        prgb[i] <= '0;
        ptol[i] <= '0;
      end
      en_mask <= '0;
      frames_req <= '0;
    end else if (bus.CfgWe) begin
      if (!bus.CfgAddr[3]) begin
        if (!bus.CfgAddr[0]) {px[bus.CfgAddr[2:1]], py[bus.CfgAddr[2:1]]} <= bus.CfgData[20:0];
        else {ptol[bus.CfgAddr[2:1]], prgb[bus.CfgAddr[2:1]]} <= bus.CfgData;
      end else if (bus.CfgAddr == 4'd8) {en_mask, frames_req} <= bus.CfgData[7:0];
    end
  end
  // y only advances for lines that actually carried active video
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x <= '0;
      y <= '0;
      line_act <= 1'b0;
    end else if (bus.VSyncPulse) begin
      x <= '0;
      y <= '0;
      line_act <= 1'b0;
    end else if (bus.HSyncPulse) begin
      x <= '0;
      if (line_act || bus.VDE) y <= (y == 10'h3ff) ? y : y + 10'd1;
      line_act <= 1'b0;
    end else if (bus.VDE) begin
      x <= (x == 11'h7ff) ? x : x + 11'd1;
      line_act <= 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_PROBES; g++) begin : g_probe
    assign hit[g] = bus.VDE && en_mask[g] && x == px[g] && y == py[g] &&
                    absd(bus.RGB[23:16], prgb[g][23:16]) <= ptol[g] &&
                    absd(bus.RGB[15:8], prgb[g][15:8]) <= ptol[g] &&
                    absd(bus.RGB[7:0], prgb[g][7:0]) <= ptol[g];
  end
  assign eval_mask  = fmask | hit;
  assign frame_ok   = en_mask != 4'd0 && (eval_mask & en_mask) == en_mask;
  assign cfg_clr    = bus.CfgWe && bus.CfgAddr <= 4'd8;
  assign sticky_clr = bus.CfgWe && bus.CfgAddr == 4'd9;
  assign req_eff    = (frames_req == 4'd0) ? 4'd1 : frames_req;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fmask <= '0;
      frame_out <= '0;
      cnt <= '0;
      det <= 1'b0;
      det_q <= 1'b0;
      stk <= 1'b0;
    end else begin
      det_q <= det;
      if (det && !det_q) stk <= 1'b1;
      else if (sticky_clr) stk <= 1'b0;
      if (!bus.Enable) begin
        fmask <= '0;
        frame_out <= '0;
        cnt <= '0;
        det <= 1'b0;
      end else begin
        det <= cnt >= req_eff;
        if (cfg_clr) begin
          fmask <= '0;
          cnt <= '0;
        end else if (bus.VSyncPulse) begin
          frame_out <= eval_mask & en_mask;
          cnt <= frame_ok ? ((cnt == 4'(MAX_FRAMES)) ? cnt : cnt + 4'd1) : 4'd0;
          fmask <= '0;
        end else fmask <= eval_mask;
      end
    end
  end
  assign bus.Detected       = det;
  assign bus.DetectedSticky = stk;
  assign bus.FrameMask      = frame_out;
  assign bus.ConsecCount    = cnt;
endmodule

// File: doc/screen_probe_ctrl.md
Name: screen_probe_ctrl

Overview:
- Software-configurable controller for pixel-probe screen detection on the HDMI/DVI capture path.
- Tracks the pixel position from the sync pulses and VDE, and compares up to 4 programmable probe points per frame against expected colours with a tolerance.
- Debounces the per-frame result over N consecutive frames and reports live and sticky detection status to the bus-facing status register.
- Replaces fixed, elaboration-time probe positions with a runtime table, so one instance serves multiple game screens.

Parameters:
- NUM_PROBES, 4, number of probe entries (fixed at 4; the address map below assumes 4).
- MAX_FRAMES, 15, saturation value of the consecutive-frame counter (4-bit).

Ports:
- CLK  input  1  pixel clock; all logic on rising edge.
- RST  input  1  asynchronous active-high reset.
- Enable  input  1  detection enable; low = idle, status forced to 0.
- VSyncPulse  input  1  single-cycle pulse at the start of vertical sync (edge-detected upstream).
- HSyncPulse  input  1  single-cycle pulse at the start of horizontal sync (edge-detected upstream).
- VDE  input  1  video data enable; pixel valid when high.
- RGB  input  24  pixel {R[23:16],G[15:8],B[7:0]}.
- CfgWe  input  1  config write strobe, one word per cycle.
- CfgAddr  input  4  config word address.
- CfgData  input  32  config write data.
- Detected  output  1  live debounced detection.
- DetectedSticky  output  1  set on Detected rising edge; cleared by software.
- FrameMask  output  4  per-probe hit mask of the last completed frame.
- ConsecCount  output  4  current consecutive-good-frame count.

Behaviour:
- Reset: all outputs 0; probe table, control register, counters and mask all 0.
- Config map:
  - Addr 2i (i=0..3): {x[20:10], y[9:0]} for probe i; CfgData[31:21] ignored.
  - Addr 2i+1: {tol[31:24], rgb[23:0]} for probe i.
  - Addr 8: {en_mask[7:4], frames_req[3:0]}.
  - Addr 9: clear DetectedSticky (data ignored).
  - Addr 10–15: ignored.
- Config writes to addr 0–8 take effect the next cycle. They also clear the in-progress frame mask and ConsecCount, so a mid-frame reconfiguration restarts debouncing.
- Position tracking:
  - x counts VDE-high cycles since the last HSyncPulse; the first active pixel is x=0.
  - y counts lines with at least one VDE-high cycle since the last VSyncPulse; the first active line is y=0. y increments on the HSyncPulse that ends an active line.
  - x saturates at 2047 and y at 1023; neither wraps.
- Probe hit: in a cycle with VDE=1, x==x_i, y==y_i and en_mask[i]=1, probe i hits if |R−R_i|, |G−G_i| and |B−B_i| are each ≤ tol_i. Differences are unsigned 8-bit absolute values with no overflow. The hit is ORed into the frame mask at the next edge.
- Frame evaluation on the VSyncPulse cycle:
  - eval_mask = frame_mask | hits_this_cycle.
  - FrameMask <= eval_mask & en_mask.
  - frame_ok = (en_mask != 0) && ((eval_mask & en_mask) == en_mask).
  - frame_ok: ConsecCount += 1, saturating at MAX_FRAMES. Otherwise ConsecCount <= 0.
  - frame_mask <= 0, y <= 0.
- Detected is registered and equals (ConsecCount ≥ max(frames_req,1)). It updates the cycle after the ConsecCount change, i.e. 2 cycles after the deciding VSyncPulse.
- DetectedSticky sets the cycle after Detected goes 0→1. If the set and an addr-9 clear occur in the same cycle, set wins.
- Simultaneous HSyncPulse and VSyncPulse: VSync handling takes priority; x <= 0, y <= 0.
- HSyncPulse with VDE=1 in the same cycle: the pixel is counted and compared at the current x; x then resets to 0.
- Enable=0:
  - Position tracking continues.
  - frame_mask, ConsecCount, FrameMask and Detected are held at 0. DetectedSticky holds its value.
  - Config writes are still accepted.
- Enable rising: debouncing starts from the next VSyncPulse. The partial first frame is evaluated normally and will usually fail.
- RST asserted mid-frame: everything returns to reset values immediately. Config must be rewritten.

Test Plan:
- Reset/idle: assert RST mid-frame with Detected=1 → all outputs 0 within the reset cycle; Detected stays 0 for frames after release until reconfigured.
- Single probe: probe0 = (83,605), rgb 0x387300, tol 4; addr8 = 0x13 (en=1, frames_req=3); feed 1280x720 frames with pixel 0x3A7102 at (83,605) → FrameMask=0001; ConsecCount 1,2,3; Detected=1 two cycles after the 3rd VSyncPulse; DetectedSticky=1 one cycle later.
- Tolerance boundary: same setup with pixel R=0x38+4 → hit; with R=0x38+5 → miss, FrameMask=0000, ConsecCount resets to 0, Detected falls.
- Two probes: probe0 (83,605)/0x387300 and probe1 (366,605)/0xD5D500, en=0011, frames_req=1; only probe1 matches → FrameMask=0010, no detect; both match → Detected=1.
- Saturation/sticky clear: 20 matching frames → ConsecCount stays 15; write addr 9 while Detected stays high → sticky 0, not re-set; clear in the same cycle as a new rising edge → sticky stays 1.
- Reconfig mid-frame: at ConsecCount=2, write addr 1 mid-frame → ConsecCount=0 and frame mask cleared; the next frame counts from 1.
